dm_subword_mem: RTL and testbench

Parametrised, latency-configurable data memory for the MEM stage of the pipelined MIPS core. It supports word, halfword and byte loads and stores with sign or zero extension, and it flags misaligned or out-of-range accesses as exceptions. A req/busy/rvalid handshake lets the pipeline stall on multi-cycle accesses. After reset, the block sweeps the array to zero one word per cycle.

---
 rtl/dm_pkg.sv | 20 ++
 rtl/dm_subword_mem_if.sv | 24 ++
 rtl/dm_lane_merge.sv | 46 ++++
 rtl/dm_subword_mem.sv | 142 ++++++++++++++
 tb/tb_dm_subword_mem.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings for the subword data memory
package dm_pkg;

  // Access size encodings carried on op
  localparam logic [2:0] MEM_W  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_HU = 3'd2;
  localparam logic [2:0] MEM_B  = 3'd3;
  localparam logic [2:0] MEM_BU = 3'd4;

  // Controller states
  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Largest supported access latency and the counter width that holds it
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dm_subword_mem_if.sv
// rtl/dm_subword_mem_if.sv - MEM-stage request/response bundle for the data memory
interface dm_subword_mem_if;
  logic        req;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;

  modport master (
    output req, we, op, addr, wdata, pc,
    input  busy, rvalid, rdata, exc_adel, exc_ades
  );

  modport slave (
    input  req, we, op, addr, wdata, pc,
    output busy, rvalid, rdata, exc_adel, exc_ades
  );
endinterface

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - byte/halfword lane insertion for stores and extraction for loads
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = lane[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[{lane, 3'b000} +: 8];

  // Store side: overwrite only the addressed lane, keep the rest of the old word
  always_comb begin
    merged = word;
    case (op)
      MEM_W:         merged = wdata;
      MEM_H, MEM_HU: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      MEM_B, MEM_BU: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      default:       merged = word;
    endcase
  end

  // Load side: pick the lane and sign- or zero-extend it
  always_comb begin
    load_data = 32'h0;
    case (op)
      MEM_W:   load_data = word;
      MEM_H:   load_data = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  load_data = {16'h0, half_sel};
      MEM_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  load_data = {24'h0, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_subword_mem.sv
// rtl/dm_subword_mem.sv - latency-configurable subword data memory; DM_WRITE_TRACE_EN enables store trace
module dm_subword_mem
  import dm_pkg::*;
#(
  parameter int          DEPTH   = 3072,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  dm_subword_mem_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dm_subword_mem: LATENCY out of range");
  end

  logic [31:0]       mem [DEPTH];

  logic [1:0]        state;
  logic [ADDR_W-1:0] clear_idx;
  logic [CNT_W-1:0]  cnt;
  logic              acc_we;
  logic [2:0]        acc_op;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
`ifdef DM_WRITE_TRACE_EN
  logic [31:0]       acc_pc;
`endif

  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              adel_q;
  logic              ades_q;

  // BASE is the byte address of word 0 and therefore word aligned
  logic [29:0]       word_off;
  logic [ADDR_W-1:0] acc_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              exc;
  logic              done;
  logic              commit;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       load_data;

  assign word_off     = acc_addr[31:2] - BASE[31:2];
  assign acc_idx      = word_off[ADDR_W-1:0];
  assign misaligned   = ((acc_op == MEM_W) && (acc_addr[1:0] != 2'b00)) ||
                        (((acc_op == MEM_H) || (acc_op == MEM_HU)) && acc_addr[0]);
  // Range is checked on the full offset so addresses beyond the index width never alias
  assign out_of_range = (acc_addr < BASE) || ({2'b00, word_off} >= 32'(DEPTH));
  assign exc          = misaligned || out_of_range || (acc_op > MEM_BU);
  assign done         = (state == ST_ACCESS) && (cnt == '0);
  assign commit       = done && acc_we && !exc;
  assign old_word     = mem[acc_idx];

  dm_lane_merge u_lane_merge (
    .op        (acc_op),
    .lane      (acc_addr[1:0]),
    .word      (old_word),
    .wdata     (acc_wdata),
    .merged    (merged),
    .load_data (load_data)
  );

  // Array port: zero sweep while clearing, merged word on a committed store
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_idx] <= 32'h0;
    end else if (commit) begin
      mem[acc_idx] <= merged;
`ifdef DM_WRITE_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, acc_pc, {acc_addr[31:2], 2'b00}, merged);
`endif
    end
  end

  // Controller: clear sweep, request capture, latency countdown and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
      cnt       <= '0;
      acc_we    <= 1'b0;
      acc_op    <= MEM_W;
      acc_addr  <= 32'h0;
      acc_wdata <= 32'h0;
`ifdef DM_WRITE_TRACE_EN
      acc_pc    <= 32'h0;
`endif
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == ADDR_W'(DEPTH - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.req) begin
            acc_we    <= bus.we;
            acc_op    <= bus.op;
            acc_addr  <= bus.addr;
            acc_wdata <= bus.wdata;
`ifdef DM_WRITE_TRACE_EN
            acc_pc    <= bus.pc;
`endif
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            rvalid_q <= 1'b1;
            rdata_q  <= (acc_we || exc) ? 32'h0 : load_data;
            ades_q   <= exc && acc_we;
            adel_q   <= exc && !acc_we;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.exc_adel = adel_q;
  assign bus.exc_ades = ades_q;

endmodule

// File: tb/tb_dm_subword_mem.sv
// tb/tb_dm_subword_mem.sv - directed-vector bench for dm_subword_mem
module tb_dm_subword_mem;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  dm_subword_mem_if bus_a ();
  dm_subword_mem_if bus_b ();

  dm_subword_mem #(.DEPTH(16), .ADDR_W(4), .BASE(32'h0), .LATENCY(3)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  dm_subword_mem #(.DEPTH(16), .ADDR_W(4), .BASE(32'h0), .LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input int sel, input logic r, input logic w, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus_a.req = r; bus_a.we = w; bus_a.op = o; bus_a.addr = a; bus_a.wdata = d; bus_a.pc = 32'h0040_0000 + a;
    end else begin
      bus_b.req = r; bus_b.we = w; bus_b.op = o; bus_b.addr = a; bus_b.wdata = d; bus_b.pc = 32'h0040_0000 + a;
    end
  endtask

  // Issue one request from an IDLE point (#1 after an edge) and wait for its completion pulse
  task automatic do_access(input int sel, input logic w, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic el,
                           output logic es, output int lat);
    int n;
    drive(sel, 1'b1, w, o, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    n = 0;
    while (((sel == 0) ? bus_a.rvalid : bus_b.rvalid) !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    rd  = (sel == 0) ? bus_a.rdata : bus_b.rdata;
    el  = (sel == 0) ? bus_a.exc_adel : bus_b.exc_adel;
    es  = (sel == 0) ? bus_a.exc_ades : bus_b.exc_ades;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus_a.busy !== 1'b1) begin $display("FAIL reset_busy: got %b expected 1", bus_a.busy); miscompares++; end
    vectors++; if (bus_a.rvalid !== 1'b0) begin $display("FAIL reset_rvalid: got %b expected 0", bus_a.rvalid); miscompares++; end
    vectors++; if (bus_a.rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h expected 00000000", bus_a.rdata); miscompares++; end
    vectors++; if ({bus_a.exc_adel, bus_a.exc_ades} !== 2'b00) begin $display("FAIL reset_exc: got %b expected 00", {bus_a.exc_adel, bus_a.exc_ades}); miscompares++; end
    reset = 1'b0;
    n = 0;
    while (bus_a.busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    vectors++; if (n !== 16) begin $display("FAIL clear_cycles: got %0d expected 16", n); miscompares++; end
  endtask

  task automatic test_clear_readback;
    logic [31:0] rd; logic el, es; int lat;
    do_access(0, 1'b0, MEM_W, 32'h3C, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0) begin $display("FAIL clear_load_3c: got %h expected 00000000", rd); miscompares++; end
    vectors++; if (el !== 1'b0) begin $display("FAIL clear_load_adel: got %b expected 0", el); miscompares++; end
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd; logic el, es; int lat;
    do_access(0, 1'b1, MEM_W, 32'h10, 32'h1234_5678, rd, el, es, lat);
    vectors++; if (lat !== 3) begin $display("FAIL store_latency: got %0d expected 3", lat); miscompares++; end
    vectors++; if (rd !== 32'h0) begin $display("FAIL store_rdata: got %h expected 00000000", rd); miscompares++; end
    vectors++; if ({el, es} !== 2'b00) begin $display("FAIL store_exc: got %b expected 00", {el, es}); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h1234_5678) begin $display("FAIL load_w_10: got %h expected 12345678", rd); miscompares++; end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic el, es; int lat;
    do_access(0, 1'b1, MEM_B, 32'h13, 32'hFFFF_FFAB, rd, el, es, lat);
    do_access(0, 1'b0, MEM_W, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hAB34_5678) begin $display("FAIL store_b_13: got %h expected ab345678", rd); miscompares++; end
    do_access(0, 1'b1, MEM_H, 32'h10, 32'h1111_BEEF, rd, el, es, lat);
    do_access(0, 1'b0, MEM_W, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hAB34_BEEF) begin $display("FAIL store_h_10: got %h expected ab34beef", rd); miscompares++; end
    do_access(0, 1'b0, MEM_B, 32'h13, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hFFFF_FFAB) begin $display("FAIL load_b_13: got %h expected ffffffab", rd); miscompares++; end
    do_access(0, 1'b0, MEM_BU, 32'h13, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0000_00AB) begin $display("FAIL load_bu_13: got %h expected 000000ab", rd); miscompares++; end
    do_access(0, 1'b0, MEM_H, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hFFFF_BEEF) begin $display("FAIL load_h_10: got %h expected ffffbeef", rd); miscompares++; end
    do_access(0, 1'b0, MEM_HU, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0000_BEEF) begin $display("FAIL load_hu_10: got %h expected 0000beef", rd); miscompares++; end
    do_access(0, 1'b0, MEM_H, 32'h12, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hFFFF_AB34) begin $display("FAIL load_h_12: got %h expected ffffab34", rd); miscompares++; end
    do_access(0, 1'b0, MEM_BU, 32'h11, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0000_00BE) begin $display("FAIL load_bu_11: got %h expected 000000be", rd); miscompares++; end
    do_access(0, 1'b1, MEM_BU, 32'h3F, 32'h0000_005A, rd, el, es, lat);
    do_access(0, 1'b0, MEM_W, 32'h3C, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h5A00_0000) begin $display("FAIL store_bu_3f: got %h expected 5a000000", rd); miscompares++; end
  endtask

  task automatic test_exceptions;
    logic [31:0] rd; logic el, es; int lat;
    do_access(0, 1'b1, MEM_W, 32'h12, 32'hDEAD_BEEF, rd, el, es, lat);
    vectors++; if ({el, es} !== 2'b01) begin $display("FAIL exc_store_w_12: got adel/ades %b expected 01", {el, es}); miscompares++; end
    vectors++; if (rd !== 32'h0) begin $display("FAIL exc_store_rdata: got %h expected 00000000", rd); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'hAB34_BEEF) begin $display("FAIL exc_no_write: got %h expected ab34beef", rd); miscompares++; end
    do_access(0, 1'b0, MEM_H, 32'h11, 32'h0, rd, el, es, lat);
    vectors++; if ({el, es} !== 2'b10) begin $display("FAIL exc_load_h_11: got adel/ades %b expected 10", {el, es}); miscompares++; end
    vectors++; if (rd !== 32'h0) begin $display("FAIL exc_load_rdata: got %h expected 00000000", rd); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h40, 32'h0, rd, el, es, lat);
    vectors++; if ({el, es} !== 2'b10) begin $display("FAIL exc_range_40: got adel/ades %b expected 10", {el, es}); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h3C, 32'h0, rd, el, es, lat);
    vectors++; if (el !== 1'b0) begin $display("FAIL last_word_ok: got adel %b expected 0", el); miscompares++; end
    do_access(0, 1'b0, 3'd5, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (el !== 1'b1) begin $display("FAIL exc_op5: got adel %b expected 1", el); miscompares++; end
    do_access(0, 1'b1, 3'd7, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (es !== 1'b1) begin $display("FAIL exc_op7_store: got ades %b expected 1", es); miscompares++; end
  endtask

  task automatic test_output_hold;
    logic [31:0] rd; logic el, es; int lat;
    do_access(0, 1'b0, MEM_BU, 32'h13, 32'h0, rd, el, es, lat);
    @(posedge clk); #1;
    vectors++; if (bus_a.rvalid !== 1'b0) begin $display("FAIL hold_rvalid_pulse: got %b expected 0", bus_a.rvalid); miscompares++; end
    vectors++; if (bus_a.rdata !== 32'h0000_00AB) begin $display("FAIL hold_rdata: got %h expected 000000ab", bus_a.rdata); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h11, 32'h0, rd, el, es, lat);
    @(posedge clk); #1;
    vectors++; if (bus_a.exc_adel !== 1'b0) begin $display("FAIL hold_adel_drop: got %b expected 0", bus_a.exc_adel); miscompares++; end
  endtask

  task automatic test_back_to_back;
    int accepts[$];
    logic prev_busy;
    int n;
    prev_busy = bus_b.busy;
    drive(1, 1'b1, 1'b0, MEM_W, 32'h10, 32'h0);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (bus_b.busy === 1'b1 && prev_busy === 1'b0) accepts.push_back(e);
      prev_busy = bus_b.busy;
    end
    drive(1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    vectors++; if (accepts.size() !== 4) begin $display("FAIL b2b_accept_count: got %0d expected 4", accepts.size()); miscompares++; end
    if (accepts.size() >= 2) begin
      vectors++; if (accepts[1] - accepts[0] !== 3) begin $display("FAIL b2b_spacing_0: got %0d expected 3", accepts[1] - accepts[0]); miscompares++; end
    end
    if (accepts.size() >= 3) begin
      vectors++; if (accepts[2] - accepts[1] !== 3) begin $display("FAIL b2b_spacing_1: got %0d expected 3", accepts[2] - accepts[1]); miscompares++; end
    end
    n = 0;
    while (bus_b.busy === 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_req_while_busy;
    int busy_seen;
    drive(1, 1'b1, 1'b0, MEM_W, 32'h10, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, MEM_W, 32'h14, 32'h0);
    vectors++; if (bus_b.busy !== 1'b1) begin $display("FAIL busy_after_accept: got %b expected 1", bus_b.busy); miscompares++; end
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    @(posedge clk); #1;
    vectors++; if (bus_b.rvalid !== 1'b1) begin $display("FAIL busy_req_completion: got %b expected 1", bus_b.rvalid); miscompares++; end
    busy_seen = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (bus_b.busy === 1'b1) busy_seen++;
    end
    vectors++; if (busy_seen !== 0) begin $display("FAIL busy_req_ignored: got %0d busy cycles expected 0", busy_seen); miscompares++; end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd; logic el, es; int lat;
    int n, rv_seen;
    drive(0, 1'b1, 1'b1, MEM_W, 32'h20, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++; if (bus_a.busy !== 1'b1) begin $display("FAIL mid_reset_busy: got %b expected 1", bus_a.busy); miscompares++; end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0; rv_seen = 0;
    while (bus_a.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus_a.rvalid === 1'b1) rv_seen++;
    end
    vectors++; if (n !== 16) begin $display("FAIL mid_reset_reclear: got %0d expected 16", n); miscompares++; end
    vectors++; if (rv_seen !== 0) begin $display("FAIL mid_reset_rvalid: got %0d pulses expected 0", rv_seen); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h20, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0) begin $display("FAIL mid_reset_word: got %h expected 00000000", rd); miscompares++; end
    do_access(0, 1'b0, MEM_W, 32'h10, 32'h0, rd, el, es, lat);
    vectors++; if (rd !== 32'h0) begin $display("FAIL mid_reset_cleared_10: got %h expected 00000000", rd); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_word_roundtrip();
    test_subword();
    test_exceptions();
    test_output_hold();
    test_back_to_back();
    test_req_while_busy();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
